// File: rtl/rc_req_tracker.sv
// Core-to-fabric request tracker: ENTRIES outstanding requests, round-robin issue to the ring,
// tag-matched read responses and broadcast returns, per-entry timeout into ERROR.
module rc_req_tracker #(
   parameter int  ENTRIES     = 4,
   parameter int  ADDR_W      = 32,
   parameter int  DATA_W      = 32,
   parameter int  TIMEOUT_CYC = 1024,
   localparam int TAG_W       = $clog2(ENTRIES)
) (
   input  logic              QClk,
   input  logic              RstQnnnH,
   input  logic              CoreReqValid,
   input  logic [1:0]        CoreReqOpcode,
   input  logic [ADDR_W-1:0] CoreReqAddr,
   input  logic [DATA_W-1:0] CoreReqData,
   output logic              CoreReqReady,
   output logic              RingReqValid,
   output logic [1:0]        RingReqOpcode,
   output logic [ADDR_W-1:0] RingReqAddr,
   output logic [DATA_W-1:0] RingReqData,
   output logic [TAG_W-1:0]  RingReqTag,
   input  logic              RingReqGrant,
   input  logic              RingRspValid,
   input  logic [TAG_W-1:0]  RingRspTag,
   input  logic [DATA_W-1:0] RingRspData,
   input  logic              BcastRetValid,
   input  logic [TAG_W-1:0]  BcastRetTag,
   output logic              CoreRspValid,
   output logic [DATA_W-1:0] CoreRspData,
   input  logic              CoreRspReady,
   input  logic              ErrClr,
   output logic              ErrSticky,
   output logic [TAG_W:0]    FreeCnt
);

   // Opcode encoding shared with the ring: RD=0, WR=1, WR_BCAST=2, RD_RSP=3.
   typedef enum logic [1:0] {
      OP_RD       = 2'd0,
      OP_WR       = 2'd1,
      OP_WR_BCAST = 2'd2,
      OP_RD_RSP   = 2'd3
   } t_opcode;

   typedef enum logic [2:0] {
      ST_FREE              = 3'd0,
      ST_WRITE             = 3'd1,
      ST_READ              = 3'd2,
      ST_READ_PRGRS        = 3'd3,
      ST_READ_RDY          = 3'd4,
      ST_WRITE_BCAST       = 3'd5,
      ST_WRITE_BCAST_PRGRS = 3'd6,
      ST_ERROR             = 3'd7
   } t_state;

   localparam int              TMR_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int              TMR_LAST_I = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_LAST_I[TMR_W-1:0];

   t_state            state_q [ENTRIES];
   t_state            state_d [ENTRIES];
   logic [ADDR_W-1:0] addr_q  [ENTRIES];
   logic [ADDR_W-1:0] addr_d  [ENTRIES];
   logic [DATA_W-1:0] data_q  [ENTRIES];
   logic [DATA_W-1:0] data_d  [ENTRIES];
   logic [TMR_W-1:0]  tmr_q   [ENTRIES];
   logic [TMR_W-1:0]  tmr_d   [ENTRIES];
   logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              err_q, err_d;
   logic [TAG_W:0]    free_cnt_q, free_cnt_d;

   logic              free_any_s, rdy_any_s, iss_any_s, err_new_s;
   logic [TAG_W-1:0]  alloc_idx_s, rdy_idx_s, iss_idx_s, cand_s;

   function automatic logic is_issuable(input t_state s);
      return (s == ST_WRITE) || (s == ST_READ) || (s == ST_WRITE_BCAST);
   endfunction

   function automatic logic is_prgrs(input t_state s);
      return (s == ST_READ_PRGRS) || (s == ST_WRITE_BCAST_PRGRS);
   endfunction

   function automatic logic [1:0] issue_op(input t_state s);
      case (s)
         ST_WRITE:       return OP_WR;
         ST_WRITE_BCAST: return OP_WR_BCAST;
         default:        return OP_RD;
      endcase
   endfunction

   // Lowest-index FREE / READ_RDY entries and the FREE popcount, all from registered state.
   always_comb begin
      free_any_s  = 1'b0;
      alloc_idx_s = '0;
      rdy_any_s   = 1'b0;
      rdy_idx_s   = '0;
      free_cnt_d  = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (state_q[i] == ST_FREE) begin
            free_any_s  = 1'b1;
            alloc_idx_s = TAG_W'(i);
            free_cnt_d  = free_cnt_d + (TAG_W + 1)'(1);
         end else begin
            free_any_s = free_any_s;
         end
         if (state_q[i] == ST_READ_RDY) begin
            rdy_any_s = 1'b1;
            rdy_idx_s = TAG_W'(i);
         end else begin
            rdy_any_s = rdy_any_s;
         end
      end
   end

   // Round-robin issue pick: descending scan so the smallest offset from rr_ptr wins.
   always_comb begin
      iss_any_s = 1'b0;
      iss_idx_s = rr_ptr_q;
      cand_s    = rr_ptr_q;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         cand_s = rr_ptr_q + TAG_W'(i);
         if (is_issuable(state_q[cand_s])) begin
            iss_any_s = 1'b1;
            iss_idx_s = cand_s;
         end else begin
            iss_any_s = iss_any_s;
         end
      end
   end

   // Output decode from registered state.
   always_comb begin
      CoreReqReady  = free_any_s;
      RingReqValid  = iss_any_s;
      RingReqOpcode = issue_op(state_q[iss_idx_s]);
      RingReqAddr   = addr_q[iss_idx_s];
      RingReqData   = data_q[iss_idx_s];
      RingReqTag    = iss_idx_s;
      CoreRspValid  = rdy_any_s;
      CoreRspData   = data_q[rdy_idx_s];
      ErrSticky     = err_q;
      FreeCnt       = free_cnt_q;
   end

   // Per-entry next state. Each entry sits in exactly one state, so at most one event applies to it.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         state_d[i] = state_q[i];
         addr_d[i]  = addr_q[i];
         data_d[i]  = data_q[i];
         tmr_d[i]   = tmr_q[i];
      end
      rr_ptr_d  = rr_ptr_q;
      err_new_s = 1'b0;

      if (CoreReqValid && free_any_s) begin
         case (CoreReqOpcode)
            OP_RD:       state_d[alloc_idx_s] = ST_READ;
            OP_WR:       state_d[alloc_idx_s] = ST_WRITE;
            OP_WR_BCAST: state_d[alloc_idx_s] = ST_WRITE_BCAST;
            default:     err_new_s = 1'b1;
         endcase
         if (CoreReqOpcode != OP_RD_RSP) begin
            addr_d[alloc_idx_s] = CoreReqAddr;
            data_d[alloc_idx_s] = CoreReqData;
         end else begin
            addr_d[alloc_idx_s] = addr_q[alloc_idx_s];
         end
      end else begin
         err_new_s = 1'b0;
      end

      if (RingReqGrant && iss_any_s) begin
         case (state_q[iss_idx_s])
            ST_WRITE:       state_d[iss_idx_s] = ST_FREE;
            ST_READ:        state_d[iss_idx_s] = ST_READ_PRGRS;
            ST_WRITE_BCAST: state_d[iss_idx_s] = ST_WRITE_BCAST_PRGRS;
            default:        state_d[iss_idx_s] = state_q[iss_idx_s];
         endcase
         tmr_d[iss_idx_s] = '0;
         rr_ptr_d         = iss_idx_s + TAG_W'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end

      if (RingRspValid) begin
         if (state_q[RingRspTag] == ST_READ_PRGRS) begin
            state_d[RingRspTag] = ST_READ_RDY;
            data_d[RingRspTag]  = RingRspData;
         end else begin
            err_new_s = 1'b1;
         end
      end else begin
         data_d[RingRspTag] = data_d[RingRspTag];
      end

      if (BcastRetValid) begin
         if (state_q[BcastRetTag] == ST_WRITE_BCAST_PRGRS) begin
            state_d[BcastRetTag] = ST_FREE;
         end else begin
            err_new_s = 1'b1;
         end
      end else begin
         state_d[BcastRetTag] = state_d[BcastRetTag];
      end

      if (rdy_any_s && CoreRspReady) begin
         state_d[rdy_idx_s] = ST_FREE;
      end else begin
         state_d[rdy_idx_s] = state_d[rdy_idx_s];
      end

      // A matching response this cycle leaves state_d moved on, so it beats expiry.
      for (int i = 0; i < ENTRIES; i++) begin
         if (is_prgrs(state_q[i]) && (state_d[i] == state_q[i]) && (TIMEOUT_CYC != 0)) begin
            if (tmr_q[i] == TMR_LAST) begin
               state_d[i] = ST_ERROR;
               err_new_s  = 1'b1;
            end else begin
               tmr_d[i] = tmr_q[i] + TMR_W'(1);
            end
         end else if ((state_q[i] == ST_ERROR) && ErrClr) begin
            state_d[i] = ST_FREE;
         end else begin
            tmr_d[i] = tmr_d[i];
         end
      end

      if (err_new_s) begin
         err_d = 1'b1;
      end else if (ErrClr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         for (int i = 0; i < ENTRIES; i++) begin
            state_q[i] <= ST_FREE;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
            tmr_q[i]   <= '0;
         end
         rr_ptr_q   <= '0;
         err_q      <= 1'b0;
         free_cnt_q <= (TAG_W + 1)'(ENTRIES);
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            state_q[i] <= state_d[i];
            addr_q[i]  <= addr_d[i];
            data_q[i]  <= data_d[i];
            tmr_q[i]   <= tmr_d[i];
         end
         rr_ptr_q   <= rr_ptr_d;
         err_q      <= err_d;
         free_cnt_q <= free_cnt_d;
      end
   end

endmodule

// File: tb/tb_rc_req_tracker.sv
// Bench for rc_req_tracker: directed scenarios then randomized traffic, all checked every cycle
// against a per-entry lifecycle model kept in the bench.
module tb_rc_req_tracker;

   localparam int N = 4;
   localparam int T = 16;
   localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_BC = 2'd2, OP_RSP = 2'd3;
   // model entry phases
   localparam int S_FREE = 0, S_WR = 1, S_RD = 2, S_RD_WAIT = 3, S_RD_DONE = 4,
                  S_BC = 5, S_BC_WAIT = 6, S_ERR = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req_valid;
   logic [1:0]  core_req_opcode;
   logic [31:0] core_req_addr, core_req_data;
   logic        core_req_ready;
   logic        ring_req_valid;
   logic [1:0]  ring_req_opcode;
   logic [31:0] ring_req_addr, ring_req_data;
   logic [1:0]  ring_req_tag;
   logic        ring_req_grant;
   logic        ring_rsp_valid;
   logic [1:0]  ring_rsp_tag;
   logic [31:0] ring_rsp_data;
   logic        bcast_ret_valid;
   logic [1:0]  bcast_ret_tag;
   logic        core_rsp_valid;
   logic [31:0] core_rsp_data;
   logic        core_rsp_ready;
   logic        err_clr;
   logic        err_sticky;
   logic [2:0]  free_cnt;

   int          n_vec = 0;
   int          n_err = 0;

   int          m_st   [N];
   int          m_age  [N];
   logic [31:0] m_addr [N];
   logic [31:0] m_data [N];
   int          m_rr;
   bit          m_err;
   int          m_freecnt;

   rc_req_tracker #(.ENTRIES(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
      .QClk(clk), .RstQnnnH(rst),
      .CoreReqValid(core_req_valid), .CoreReqOpcode(core_req_opcode),
      .CoreReqAddr(core_req_addr), .CoreReqData(core_req_data), .CoreReqReady(core_req_ready),
      .RingReqValid(ring_req_valid), .RingReqOpcode(ring_req_opcode), .RingReqAddr(ring_req_addr),
      .RingReqData(ring_req_data), .RingReqTag(ring_req_tag), .RingReqGrant(ring_req_grant),
      .RingRspValid(ring_rsp_valid), .RingRspTag(ring_rsp_tag), .RingRspData(ring_rsp_data),
      .BcastRetValid(bcast_ret_valid), .BcastRetTag(bcast_ret_tag),
      .CoreRspValid(core_rsp_valid), .CoreRspData(core_rsp_data), .CoreRspReady(core_rsp_ready),
      .ErrClr(err_clr), .ErrSticky(err_sticky), .FreeCnt(free_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_any_free();
      for (int i = 0; i < N; i++) if (m_st[i] == S_FREE) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_issue();
      for (int k = 0; k < N; k++) begin
         int j = (m_rr + k) % N;
         if (m_st[j] == S_WR || m_st[j] == S_RD || m_st[j] == S_BC) return j;
      end
      return -1;
   endfunction

   function automatic int m_done();
      for (int i = 0; i < N; i++) if (m_st[i] == S_RD_DONE) return i;
      return -1;
   endfunction

   // Advance the model over one clock edge using the inputs presented during that cycle.
   task automatic model_edge();
      int  nst [N];
      int  nfree, j, d;
      bit  new_err;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_st[i] = S_FREE; m_age[i] = 0; m_addr[i] = '0; m_data[i] = '0;
         end
         m_rr = 0; m_err = 1'b0; m_freecnt = N;
         return;
      end
      nfree = 0;
      for (int i = 0; i < N; i++) begin
         nst[i] = m_st[i];
         if (m_st[i] == S_FREE) nfree++;
      end
      new_err = 1'b0;
      if (core_req_valid && m_any_free()) begin
         if (core_req_opcode == OP_RSP) new_err = 1'b1;
         else begin
            j = 0;
            while (m_st[j] != S_FREE) j++;
            nst[j] = (core_req_opcode == OP_RD) ? S_RD : (core_req_opcode == OP_WR) ? S_WR : S_BC;
            m_addr[j] = core_req_addr;
            m_data[j] = core_req_data;
         end
      end
      j = m_issue();
      if (ring_req_grant && j >= 0) begin
         nst[j] = (m_st[j] == S_WR) ? S_FREE : (m_st[j] == S_RD) ? S_RD_WAIT : S_BC_WAIT;
         m_age[j] = 0;
         m_rr = (j + 1) % N;
      end
      if (ring_rsp_valid) begin
         if (m_st[ring_rsp_tag] == S_RD_WAIT) begin
            nst[ring_rsp_tag] = S_RD_DONE;
            m_data[ring_rsp_tag] = ring_rsp_data;
         end else new_err = 1'b1;
      end
      if (bcast_ret_valid) begin
         if (m_st[bcast_ret_tag] == S_BC_WAIT) nst[bcast_ret_tag] = S_FREE;
         else new_err = 1'b1;
      end
      d = m_done();
      if (d >= 0 && core_rsp_ready) nst[d] = S_FREE;
      for (int i = 0; i < N; i++) begin
         if ((m_st[i] == S_RD_WAIT || m_st[i] == S_BC_WAIT) && nst[i] == m_st[i]) begin
            // the cycle just ending is cycle number age+1 spent waiting
            if (m_age[i] + 1 >= T) begin
               nst[i] = S_ERR;
               new_err = 1'b1;
            end else m_age[i]++;
         end
         if (m_st[i] == S_ERR && err_clr) nst[i] = S_FREE;
      end
      m_err = new_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
      m_freecnt = nfree;
      for (int i = 0; i < N; i++) m_st[i] = nst[i];
   endtask

   task automatic check_outputs();
      int j, d;
      logic [1:0] eop;
      check_eq("core_req_ready", core_req_ready, m_any_free());
      j = m_issue();
      check_eq("ring_req_valid", ring_req_valid, j >= 0);
      if (j >= 0) begin
         eop = (m_st[j] == S_WR) ? OP_WR : (m_st[j] == S_RD) ? OP_RD : OP_BC;
         check_eq("ring_req_opcode", ring_req_opcode, eop);
         check_eq("ring_req_addr", ring_req_addr, m_addr[j]);
         check_eq("ring_req_data", ring_req_data, m_data[j]);
         check_eq("ring_req_tag", ring_req_tag, j);
      end
      d = m_done();
      check_eq("core_rsp_valid", core_rsp_valid, d >= 0);
      if (d >= 0) check_eq("core_rsp_data", core_rsp_data, m_data[d]);
      check_eq("err_sticky", err_sticky, m_err);
      check_eq("free_cnt", free_cnt, m_freecnt);
   endtask

   task automatic idle();
      rst = 1'b0; core_req_valid = 1'b0; core_req_opcode = OP_RD;
      core_req_addr = '0; core_req_data = '0; ring_req_grant = 1'b0;
      ring_rsp_valid = 1'b0; ring_rsp_tag = '0; ring_rsp_data = '0;
      bcast_ret_valid = 1'b0; bcast_ret_tag = '0; core_rsp_ready = 1'b0; err_clr = 1'b0;
   endtask

   // One clock: edge, model update, then compare on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] dd);
      idle(); core_req_valid = 1'b1; core_req_opcode = op; core_req_addr = a; core_req_data = dd;
      cycle();
   endtask

   task automatic grant_cycle();
      idle(); ring_req_grant = 1'b1; cycle();
   endtask

   task automatic do_reset();
      idle(); rst = 1'b1; cycle(); idle();
   endtask

   task automatic random_inputs();
      int cand [$];
      int r;
      idle();
      rst = ($urandom_range(0, 299) == 0);
      core_req_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 15);
      core_req_opcode = (r == 0) ? OP_RSP : 2'(r % 3);
      core_req_addr = $urandom; core_req_data = $urandom;
      ring_req_grant = $urandom_range(0, 1);
      core_rsp_ready = ($urandom_range(0, 9) < 6);
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) < 4) begin
         ring_rsp_valid = 1'b1; ring_rsp_data = $urandom;
         for (int i = 0; i < N; i++) if (m_st[i] == S_RD_WAIT) cand.push_back(i);
         if (cand.size() > 0 && $urandom_range(0, 7) != 0)
            ring_rsp_tag = 2'(cand[$urandom_range(0, cand.size() - 1)]);
         else ring_rsp_tag = 2'($urandom_range(0, N - 1));
      end
      cand.delete();
      if ($urandom_range(0, 9) < 4) begin
         bcast_ret_valid = 1'b1;
         for (int i = 0; i < N; i++) if (m_st[i] == S_BC_WAIT) cand.push_back(i);
         if (cand.size() > 0 && $urandom_range(0, 7) != 0)
            bcast_ret_tag = 2'(cand[$urandom_range(0, cand.size() - 1)]);
         else bcast_ret_tag = 2'($urandom_range(0, N - 1));
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(negedge clk);
      cycle();
      check_eq("rst_free_cnt", free_cnt, 3'd4);
      check_eq("rst_ready", core_req_ready, 1'b1);
      check_eq("rst_ring_valid", ring_req_valid, 1'b0);
      check_eq("rst_err", err_sticky, 1'b0);
      idle();

      // single write, granted the cycle after allocation
      req(OP_WR, 32'h0040_0010, 32'hDEAD_BEEF);
      check_eq("d1_op", ring_req_opcode, OP_WR);
      check_eq("d1_tag", ring_req_tag, 2'd0);
      check_eq("d1_addr", ring_req_addr, 32'h0040_0010);
      grant_cycle();
      idle(); cycle();
      check_eq("d1_free_cnt", free_cnt, 3'd4);

      // fill all entries with reads, fifth held off, then a tagged response
      do_reset();
      for (int i = 0; i < 4; i++) req(OP_RD, 32'h100 + 32'(i), 32'h0);
      check_eq("d2_ready", core_req_ready, 1'b0);
      req(OP_RD, 32'h200, 32'h0);
      check_eq("d2_free_cnt", free_cnt, 3'd0);
      for (int i = 0; i < 4; i++) grant_cycle();
      idle(); ring_rsp_valid = 1'b1; ring_rsp_tag = 2'd2; ring_rsp_data = 32'h55; cycle();
      check_eq("d2_rsp_valid", core_rsp_valid, 1'b1);
      check_eq("d2_rsp_data", core_rsp_data, 32'h55);

      // broadcast return after 10 cycles, then a stray return to a FREE tag
      do_reset();
      req(OP_BC, 32'h300, 32'h1);
      grant_cycle();
      idle(); for (int i = 0; i < 10; i++) cycle();
      bcast_ret_valid = 1'b1; bcast_ret_tag = 2'd0; cycle(); idle();
      check_eq("d3_err_clean", err_sticky, 1'b0);
      bcast_ret_valid = 1'b1; bcast_ret_tag = 2'd1; cycle(); idle();
      check_eq("d3_err_stray", err_sticky, 1'b1);

      // read timeout after 16 waiting cycles, released by ErrClr
      do_reset();
      req(OP_RD, 32'h400, 32'h0);
      grant_cycle();
      idle(); for (int i = 0; i < 15; i++) cycle();
      check_eq("d4_err_before", err_sticky, 1'b0);
      cycle();
      check_eq("d4_err_timeout", err_sticky, 1'b1);
      err_clr = 1'b1; cycle(); idle();
      check_eq("d4_err_clr", err_sticky, 1'b0);
      check_eq("d4_ready", core_req_ready, 1'b1);

      // response on the expiry cycle wins over the timeout
      do_reset();
      req(OP_RD, 32'h500, 32'h0);
      grant_cycle();
      idle(); for (int i = 0; i < 15; i++) cycle();
      ring_rsp_valid = 1'b1; ring_rsp_tag = 2'd0; ring_rsp_data = 32'h1234; cycle(); idle();
      check_eq("d5_rsp_valid", core_rsp_valid, 1'b1);
      check_eq("d5_rsp_data", core_rsp_data, 32'h1234);
      check_eq("d5_err", err_sticky, 1'b0);

      // reset with three reads in flight, then a late response is unexpected
      do_reset();
      for (int i = 0; i < 3; i++) req(OP_RD, 32'h600 + 32'(i), 32'h0);
      for (int i = 0; i < 3; i++) grant_cycle();
      do_reset();
      check_eq("d5_rst_free_cnt", free_cnt, 3'd4);
      ring_rsp_valid = 1'b1; ring_rsp_tag = 2'd0; cycle(); idle();
      check_eq("d5_late_rsp_err", err_sticky, 1'b1);

      // round-robin issue order with wrap 3 -> 0
      do_reset();
      for (int i = 0; i < 4; i++) req(OP_WR, 32'h700 + 32'(i), 32'(i));
      check_eq("rr_tag_0", ring_req_tag, 2'd0); grant_cycle();
      check_eq("rr_tag_1", ring_req_tag, 2'd1); grant_cycle();
      req(OP_WR, 32'h800, 32'h8);
      req(OP_WR, 32'h801, 32'h9);
      begin
         logic [1:0] exp_tags [4];
         exp_tags[0] = 2'd2; exp_tags[1] = 2'd3; exp_tags[2] = 2'd0; exp_tags[3] = 2'd1;
         for (int i = 0; i < 4; i++) begin
            check_eq("rr_wrap_tag", ring_req_tag, exp_tags[i]);
            grant_cycle();
         end
      end
      idle(); cycle();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         random_inputs();
         cycle();
      end
      idle(); cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
